truth_table_sweeper: RTL and testbench

- Drives every input combination into a combinational N-input, 1-output function under test.
- Holds each combination for a programmable dwell period, samples the function output at the end of the dwell, and assembles the full truth table.
- Sits directly upstream and downstream of the combinational lab functions (4-input a,b,c,d -> f). It replaces hand-written stimulus sequences with a clocked, self-capturing sweeper.

---
 rtl/truth_table_sweeper_pkg.sv | 14 +
 rtl/truth_table_sweeper_if.sv | 22 ++
 rtl/truth_table_sweeper_dwell_timer.sv | 30 +++
 rtl/truth_table_sweeper.sv | 96 +++++++++
 tb/tb_truth_table_sweeper.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// truth_table_sweeper_pkg: shared FSM state type, dwell limits and counter width helper
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    localparam int DWELL_MIN = 2;
    localparam int DWELL_MAX = 65535;

    // Dwell counter only ever holds DWELL-1 down to 0.
    function automatic int cnt_w(input int dwell);
        return $clog2(dwell);
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: sweeper <-> function-under-test and result bus
// master: sweeper side (drives abcd and results, reads start and f_in)
// slave : environment side (drives start and f_in, reads abcd and results)
interface truth_table_sweeper_if #(parameter int N_IN = 4);
    logic                 start;
    logic                 f_in;
    logic [N_IN-1:0]      abcd;
    logic                 busy;
    logic                 done;
    logic [2**N_IN-1:0]   table_out;
    logic [N_IN:0]        minterm_count;

    modport master (
        input  start, f_in,
        output abcd, busy, done, table_out, minterm_count
    );

    modport slave (
        output start, f_in,
        input  abcd, busy, done, table_out, minterm_count
    );
endinterface

// File: rtl/truth_table_sweeper_dwell_timer.sv
// truth_table_sweeper_dwell_timer: loadable down-counter timing each vector's dwell
// clk, rst : clock, synchronous active-high reset (count -> 0)
// load     : force count to load_val
// reload   : reload load_val when the count reaches 0 (back-to-back dwells)
// load_val : value loaded, normally DWELL-1
// expire   : count is 0 and no load is happening this cycle
module truth_table_sweeper_dwell_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         reload,
    input  logic [W-1:0] load_val,
    output logic         expire
);
    logic [W-1:0] count_q, count_d;
    logic         zero;

    always_comb begin
        zero    = count_q == '0;
        count_d = (load || (reload && zero)) ? load_val : zero ? count_q : count_q - W'(1);
        expire  = zero && !load;
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps every input vector through a combinational function and captures its truth table
// clk, rst : clock, synchronous active-high reset
// bus      : start/f_in in; abcd, busy, done, table_out, minterm_count out (all registered)
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int DWELL = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    truth_table_sweeper_if.master  bus
);
    localparam int              NV   = 2**N_IN;
    localparam int              CW   = cnt_w(DWELL);
    localparam logic [N_IN-1:0] LAST = N_IN'(NV - 1);

    if (DWELL < DWELL_MIN || DWELL > DWELL_MAX) begin : g_bad_dwell
        $error("truth_table_sweeper: DWELL out of range");
    end

    state_t          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [NV-1:0]   tbl_q, tbl_d;
    logic [N_IN:0]   mc_q, mc_d;
    logic            load, reload, expire;

    // Counter restarts on every vector except the last, so it sits at 0 once the sweep ends.
    assign load   = state_q == IDLE && bus.start;
    assign reload = state_q == SWEEP && idx_q != LAST;

    truth_table_sweeper_dwell_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .reload   (reload),
        .load_val (CW'(DWELL - 1)),
        .expire   (expire)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tbl_d   = tbl_q;
        mc_d    = mc_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = SWEEP;
                busy_d  = 1'b1;
                idx_d   = '0;
                tbl_d   = '0;
                mc_d    = '0;
            end
            SWEEP: if (expire) begin
                tbl_d[idx_q] = bus.f_in;
                mc_d         = mc_q + (N_IN+1)'(bus.f_in);
                if (idx_q == LAST) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + N_IN'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tbl_q   <= '0;
            mc_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tbl_q   <= tbl_d;
            mc_q    <= mc_d;
        end
    end

    assign bus.abcd          = idx_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.table_out     = tbl_q;
    assign bus.minterm_count = mc_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed sweeps of two sweepers (DWELL 20 and 2) against a result scoreboard
module tb_truth_table_sweeper;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_r = 1'b0;
    logic sel = 1'b0;
    int   cyc = 0;
    int   mode = 0;
    int   c0 = 0;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    truth_table_sweeper_if #(.N_IN(4)) ia();
    truth_table_sweeper_if #(.N_IN(4)) ib();

    truth_table_sweeper #(.N_IN(4), .DWELL(20)) dut_a (.clk(clk), .rst(rst), .bus(ia.master));
    truth_table_sweeper #(.N_IN(4), .DWELL(2))  dut_b (.clk(clk), .rst(rst), .bus(ib.master));

    // Reference functions; mode 4 is 1 except on the last cycle of each dwell.
    function automatic logic fmodel(input int m, input logic [3:0] v, input int age, input int d);
        case (m)
            1:       return v[0];
            2:       return v[3] & v[2];
            3:       return ^v;
            4:       return (age % d) != d - 1;
            default: return 1'b0;
        endcase
    endfunction

    assign ia.start = start_r & ~sel;
    assign ib.start = start_r & sel;
    always_comb ia.f_in = fmodel(mode, ia.abcd, cyc - c0, 20);
    always_comb ib.f_in = fmodel(mode, ib.abcd, cyc - c0, 2);

    logic [3:0]  o_abcd;
    logic        o_busy, o_done;
    logic [15:0] o_tbl;
    logic [4:0]  o_mc;
    assign o_abcd = sel ? ib.abcd : ia.abcd;
    assign o_busy = sel ? ib.busy : ia.busy;
    assign o_done = sel ? ib.done : ia.done;
    assign o_tbl  = sel ? ib.table_out : ia.table_out;
    assign o_mc   = sel ? ib.minterm_count : ia.minterm_count;

    typedef struct {
        logic [15:0] tbl;
        logic [4:0]  mc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sweep(input logic s, input int m, input logic [15:0] et, input logic [4:0] emc, input int inj);
        int   d;
        int   g;
        exp_t e;
        d    = s ? 2 : 20;
        sel  = s;
        mode = m;
        sb.push_back('{et, emc, 16 * d});
        @(negedge clk);
        start_r = 1'b1;
        c0      = cyc + 1;
        @(negedge clk);
        start_r = 1'b0;
        chk("start_busy", 32'(o_busy), 1);
        chk("start_tbl_clr", 32'(o_tbl), 0);
        chk("start_mc_clr", 32'(o_mc), 0);
        g = 0;
        while (!o_done && g < 400) begin
            chk("abcd_step", 32'(o_abcd), 32'((cyc - c0) / d));
            chk("busy_hold", 32'(o_busy), 1);
            start_r = (g == inj);
            @(negedge clk);
            g++;
        end
        start_r = 1'b0;
        chk("done_seen", 32'(o_done), 1);
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("done_latency", 32'(cyc - c0), 32'(e.lat));
            chk("table_out", 32'(o_tbl), 32'(e.tbl));
            chk("minterm_count", 32'(o_mc), 32'(e.mc));
        end
        chk("done_busy_low", 32'(o_busy), 0);
        chk("done_abcd_last", 32'(o_abcd), 15);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        chk("done_pulse_end", 32'(o_done), 0);
        chk("idle_busy", 32'(o_busy), 0);
        chk("idle_tbl_hold", 32'(o_tbl), 32'(et));
        chk("idle_abcd_hold", 32'(o_abcd), 15);
    endtask

    initial begin
        int g;
        repeat (3) @(negedge clk);
        chk("rst_abcd_a", 32'(ia.abcd), 0);
        chk("rst_busy_a", 32'(ia.busy), 0);
        chk("rst_done_a", 32'(ia.done), 0);
        chk("rst_tbl_a", 32'(ia.table_out), 0);
        chk("rst_mc_a", 32'(ia.minterm_count), 0);
        chk("rst_tbl_b", 32'(ib.table_out), 0);
        chk("rst_busy_b", 32'(ib.busy), 0);
        rst = 1'b0;
        @(negedge clk);

        sweep(1'b0, 0, 16'h0000, 5'd0, 5);
        sweep(1'b0, 1, 16'hAAAA, 5'd8, 100);
        sweep(1'b0, 2, 16'hF000, 5'd4, 7);
        sweep(1'b0, 2, 16'hF000, 5'd4, -1);
        sweep(1'b1, 3, 16'h6996, 5'd8, 9);
        sweep(1'b0, 4, 16'h0000, 5'd0, 50);

        sel  = 1'b0;
        mode = 1;
        @(negedge clk);
        start_r = 1'b1;
        c0      = cyc + 1;
        @(negedge clk);
        start_r = 1'b0;
        g = 0;
        while (ia.abcd != 4'd5 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("mid_reached_5", 32'(ia.abcd), 5);
        chk("mid_partial_tbl", 32'(ia.table_out), 32'h000A);
        chk("mid_partial_mc", 32'(ia.minterm_count), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_abcd", 32'(ia.abcd), 0);
        chk("mid_rst_busy", 32'(ia.busy), 0);
        chk("mid_rst_tbl", 32'(ia.table_out), 0);
        chk("mid_rst_mc", 32'(ia.minterm_count), 0);
        chk("mid_rst_done", 32'(ia.done), 0);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk("post_rst_no_done", 32'(ia.done), 0);
        end
        sweep(1'b0, 1, 16'hAAAA, 5'd8, -1);

        sel     = 1'b0;
        rst     = 1'b1;
        start_r = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        start_r = 1'b0;
        chk("rst_beats_start", 32'(ia.busy), 0);
        @(negedge clk);
        chk("rst_start_idle", 32'(ia.busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
